// File: rtl/boid_frame_writer_pkg.sv
// Shared constants and state encoding for the boid frame writer.
// Also used by the VGA read path for display RAM geometry.
package boid_pkg;

  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int PIXEL_COUNT  = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int ADDR_WIDTH   = 19;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/boid_frame_writer_pixel_addr_calc.sv
// Combinational (x, y) -> {in_bounds, linear address} for the display RAM.
// Multiplies by the constant screen width with shifts and adds only.
module pixel_addr_calc #(
  parameter int VIDEO_WIDTH  = 640,
  parameter int VIDEO_HEIGHT = 480,
  parameter int ADDR_WIDTH   = 19,
  parameter int XW           = 11,
  parameter int YW           = 10
) (
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  output logic                  in_bounds,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int AW1 = ADDR_WIDTH + 1;

  localparam logic [31:0]   WC   = 32'(VIDEO_WIDTH);
  localparam logic [XW-1:0] XLIM = XW'(VIDEO_WIDTH);
  localparam logic [YW-1:0] YLIM = YW'(VIDEO_HEIGHT);

  logic [AW1-1:0] yy;
  logic [AW1-1:0] xx;
  logic [AW1-1:0] acc;

  assign yy = AW1'(y);
  assign xx = AW1'(x);

  // One shifted copy of y per set bit of the width constant.
  always_comb begin
    acc = '0;
    for (int b = 0; b < 32; b++) begin
      if (WC[b]) acc = acc + (yy << b);
    end
    acc = acc + xx;
  end

  assign in_bounds = (x < XLIM) && (y < YLIM);
  assign addr      = acc[ADDR_WIDTH-1:0];

endmodule

// File: rtl/boid_frame_writer.sv
// Per-frame sequencer: clear display RAM, then draw a square per boid.
// Pixels falling off-screen still take a cycle but are not written.
module boid_frame_writer #(
  parameter int MAX_BOIDS    = 4,
  parameter int BOID_SIZE    = 2,
  parameter int VIDEO_WIDTH  = boid_pkg::VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT = boid_pkg::VIDEO_HEIGHT,
  parameter int ADDR_WIDTH   = boid_pkg::ADDR_WIDTH,
  localparam int BOID_BITS   = (MAX_BOIDS > 1) ? $clog2(MAX_BOIDS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  screen_end,
  output logic [BOID_BITS-1:0]  boid_sel,
  input  logic [9:0]            boid_x,
  input  logic [8:0]            boid_y,
  output logic                  ram_clear,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  import boid_pkg::*;

  localparam int DW = (BOID_SIZE > 1) ? $clog2(BOID_SIZE) : 1;

  localparam logic [DW-1:0]        LAST_D   = DW'(BOID_SIZE - 1);
  localparam logic [BOID_BITS-1:0] LAST_SEL = BOID_BITS'(MAX_BOIDS - 1);

  state_t               state, state_n;
  logic [BOID_BITS-1:0] sel_n;
  logic [DW-1:0]        dx, dx_n;
  logic [DW-1:0]        dy, dy_n;
  logic [9:0]           px, px_n;
  logic [8:0]           py, py_n;

  logic [10:0]           pix_x;
  logic [9:0]            pix_y;
  logic                  pix_ok;
  logic [ADDR_WIDTH-1:0] pix_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      boid_sel <= '0;
      dx       <= '0;
      dy       <= '0;
      px       <= '0;
      py       <= '0;
    end else begin
      state    <= state_n;
      boid_sel <= sel_n;
      dx       <= dx_n;
      dy       <= dy_n;
      px       <= px_n;
      py       <= py_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = boid_sel;
    dx_n    = dx;
    dy_n    = dy;
    px_n    = px;
    py_n    = py;
    unique case (state)
      IDLE: begin
        sel_n = '0;
        if (screen_end) state_n = CLEAR;
      end
      CLEAR: begin
        state_n = LOAD;
      end
      LOAD: begin
        px_n    = boid_x;
        py_n    = boid_y;
        dx_n    = '0;
        dy_n    = '0;
        state_n = DRAW;
      end
      DRAW: begin
        if (dx == LAST_D) begin
          dx_n = '0;
          if (dy == LAST_D) begin
            dy_n = '0;
            if (boid_sel == LAST_SEL) begin
              state_n = DONE;
            end else begin
              sel_n   = boid_sel + 1'b1;
              state_n = LOAD;
            end
          end else begin
            dy_n = dy + 1'b1;
          end
        end else begin
          dx_n = dx + 1'b1;
        end
      end
      DONE: begin
        sel_n   = '0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // One bit wider than the latched position so edge pixels clip, not wrap.
  assign pix_x = {1'b0, px} + 11'(dx);
  assign pix_y = {1'b0, py} + 10'(dy);

  pixel_addr_calc #(
    .VIDEO_WIDTH  (VIDEO_WIDTH),
    .VIDEO_HEIGHT (VIDEO_HEIGHT),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .XW           (11),
    .YW           (10)
  ) u_addr (
    .x         (pix_x),
    .y         (pix_y),
    .in_bounds (pix_ok),
    .addr      (pix_addr)
  );

  assign busy       = (state != IDLE);
  assign ram_clear  = (state == CLEAR);
  assign frame_done = (state == DONE);
  assign ram_we     = (state == DRAW) && pix_ok;
  assign ram_waddr  = ram_we ? pix_addr : '0;
  assign overrun    = screen_end && busy;

endmodule

// File: tb/tb_boid_frame_writer.sv
// Directed bench for boid_frame_writer at default parameters.
// Per-cycle expectations come from a small frame-timing model.
module tb_boid_frame_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        screen_end = 1'b0;
  logic [1:0]  boid_sel;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic        ram_clear;
  logic        ram_we;
  logic [18:0] ram_waddr;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  logic [9:0] bx [4];
  logic [8:0] by [4];
  int         ex [4];
  int         ey [4];

  int nchk = 0;
  int nfail = 0;
  int wlog [$];

  always #10 clock = ~clock;

  assign boid_x = bx[boid_sel];
  assign boid_y = by[boid_sel];

  boid_frame_writer dut (
    .clock      (clock),
    .reset      (reset),
    .screen_end (screen_end),
    .boid_sel   (boid_sel),
    .boid_x     (boid_x),
    .boid_y     (boid_y),
    .ram_clear  (ram_clear),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input int exp);
    int got;
    got = (idx < wlog.size()) ? wlog[idx] : -1;
    chk(tag, got, exp);
  endtask

  task automatic set_boids(input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2,
                           input int x3, input int y3);
    ex[0] = x0; ey[0] = y0;
    ex[1] = x1; ey[1] = y1;
    ex[2] = x2; ey[2] = y2;
    ex[3] = x3; ey[3] = y3;
    for (int i = 0; i < 4; i++) begin
      bx[i] = 10'(ex[i]);
      by[i] = 9'(ey[i]);
    end
  endtask

  // Cycle k is the k-th cycle after the edge that samples screen_end.
  task automatic run_frame(input int ovr_k, input int rst_k,
                           input int chg_k, input int chg_val);
    int j, i, p, x, y;
    int e_we, e_addr, e_sel, e_busy, e_clr, e_done, e_ovr;
    wlog.delete();
    @(posedge clock); #1 screen_end = 1'b1;
    @(posedge clock); #1 screen_end = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == ovr_k) screen_end = 1'b1;
      if (k == rst_k) reset = 1'b1;
      if (k == chg_k) bx[1] = 10'(chg_val);
      @(negedge clock);
      e_busy = (k <= 22) ? 1 : 0;
      e_clr  = (k == 1) ? 1 : 0;
      e_done = (k == 22) ? 1 : 0;
      e_we = 0; e_addr = 0; e_sel = 0;
      if (k >= 3 && k <= 22) begin
        j = k - 3; i = j / 5; p = j % 5;
        if (p == 4) e_sel = (i == 3) ? 3 : i + 1;
        else e_sel = i;
        if (p < 4) begin
          x = ex[i] + p % 2;
          y = ey[i] + p / 2;
          if (x < 640 && y < 480) begin
            e_we = 1;
            e_addr = y * 640 + x;
          end
        end
      end
      if (rst_k > 0 && k > rst_k) begin
        e_busy = 0; e_clr = 0; e_done = 0;
        e_we = 0; e_addr = 0; e_sel = 0;
      end
      e_ovr = (k == ovr_k && e_busy == 1) ? 1 : 0;
      chk($sformatf("we@%0d", k), ram_we, e_we);
      chk($sformatf("addr@%0d", k), ram_waddr, e_addr);
      chk($sformatf("sel@%0d", k), boid_sel, e_sel);
      chk($sformatf("busy@%0d", k), busy, e_busy);
      chk($sformatf("clr@%0d", k), ram_clear, e_clr);
      chk($sformatf("done@%0d", k), frame_done, e_done);
      chk($sformatf("ovr@%0d", k), overrun, e_ovr);
      if (ram_we === 1'b1) wlog.push_back(int'(ram_waddr));
      @(posedge clock); #1;
      screen_end = 1'b0;
      reset = 1'b0;
    end
  endtask

  initial begin
    set_boids(10, 5, 100, 100, 200, 200, 300, 300);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_waddr, 0);
    chk("rst_clr", ram_clear, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_sel", boid_sel, 0);
    chk("rst_ovr", overrun, 0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(posedge clock);

    run_frame(0, 0, 0, 0);
    chk("f1_nw", wlog.size(), 16);
    chk_log("f1_w0", 0, 3210);
    chk_log("f1_w1", 1, 3211);
    chk_log("f1_w2", 2, 3850);
    chk_log("f1_w3", 3, 3851);
    chk_log("f1_w4", 4, 64100);
    chk_log("f1_w15", 15, 192941);

    set_boids(10, 5, 639, 479, 639, 0, 638, 479);
    run_frame(0, 0, 0, 0);
    chk("f2_nw", wlog.size(), 9);
    chk_log("f2_w4", 4, 307199);
    chk_log("f2_w5", 5, 639);
    chk_log("f2_w6", 6, 1279);
    chk_log("f2_w7", 7, 307198);
    chk_log("f2_w8", 8, 307199);

    set_boids(10, 5, 100, 100, 200, 200, 300, 300);
    run_frame(10, 0, 0, 0);
    chk("f3_nw", wlog.size(), 16);

    run_frame(22, 0, 0, 0);
    chk("f4_nw", wlog.size(), 16);

    run_frame(0, 8, 0, 0);
    chk("f5_nw", wlog.size(), 5);

    run_frame(0, 0, 9, 400);
    chk("f6_nw", wlog.size(), 16);
    chk_log("f6_w4", 4, 64100);
    chk_log("f6_w7", 7, 64741);
    bx[1] = 10'(ex[1]);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
